// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with a one-cycle-latency pixel fetch.
// Outputs hsync/vsync/blank_n/colour mutually aligned, two enabled cycles behind px_*.
// Optional build macro VGA_PATTERN_EN adds internal 8-bar colour pattern on pattern_sel.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          SYNC_POL = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       pattern_sel,
   output logic [9:0] px_x,
   output logic [9:0] px_y,
   output logic       px_valid,
   input  logic [7:0] pix_r,
   input  logic [7:0] pix_g,
   input  logic [7:0] pix_b,
   output logic [7:0] reg_r,
   output logic [7:0] reg_g,
   output logic [7:0] reg_b,
   output logic       hsync,
   output logic       vsync,
   output logic       blank_n,
   output logic       frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [9:0] h_cnt_q, h_cnt_d;
   logic [9:0] v_cnt_q, v_cnt_d;
   logic       act_raw, hs_raw, vs_raw;

   // Stage 1 companions of px_*
   logic s1_hs_q, s1_vs_q;
   // Delay stage: lines up with pix_* returned by the source
   logic s2_act_q, s2_hs_q, s2_vs_q, s2_fs_q;

   // Raster counters next state: line wrap bumps v_cnt on the same edge
   always_comb begin
      h_cnt_d = h_cnt_q + 10'd1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end
   end

   // Raw active/sync decode from the counters
   always_comb begin
      act_raw = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      hs_raw  = (h_cnt_q >= H_SS) && (h_cnt_q < H_SE);
      vs_raw  = (v_cnt_q >= V_SS) && (v_cnt_q < V_SE);
   end

   // Counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else if (en) begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   // Stage 1: pixel request plus delayed sync levels
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         px_x     <= '0;
         px_y     <= '0;
         px_valid <= 1'b0;
         s1_hs_q  <= 1'b0;
         s1_vs_q  <= 1'b0;
      end else if (en) begin
         px_x     <= h_cnt_q;
         px_y     <= v_cnt_q;
         px_valid <= act_raw;
         s1_hs_q  <= hs_raw;
         s1_vs_q  <= vs_raw;
      end
   end

   // Delay stage: wait out the source's one-cycle read latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_act_q <= 1'b0;
         s2_hs_q  <= 1'b0;
         s2_vs_q  <= 1'b0;
         s2_fs_q  <= 1'b0;
      end else if (en) begin
         s2_act_q <= px_valid;
         s2_hs_q  <= s1_hs_q;
         s2_vs_q  <= s1_vs_q;
         s2_fs_q  <= px_valid && (px_x == 10'd0) && (px_y == 10'd0);
      end
   end

`ifdef VGA_PATTERN_EN
   localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);

   logic       s2_pat_q;
   logic [2:0] s2_bar_q;
   logic [2:0] bar_idx;

   // Bar index of the stage-1 column
   always_comb begin
      bar_idx = 3'(px_x / BAR_W);
   end

   // Pattern select and bar travel with the request, sampled at stage 1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_pat_q <= 1'b0;
         s2_bar_q <= '0;
      end else if (en) begin
         s2_pat_q <= pattern_sel;
         s2_bar_q <= bar_idx;
      end
   end
`else
   logic unused_pattern_sel;
   assign unused_pattern_sel = pattern_sel;
`endif

   // Stage 2: colour is forced to zero outside the active area
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_r       <= '0;
         reg_g       <= '0;
         reg_b       <= '0;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         blank_n     <= 1'b0;
         frame_start <= 1'b0;
      end else if (en) begin
         if (!s2_act_q) begin
            reg_r <= '0;
            reg_g <= '0;
            reg_b <= '0;
`ifdef VGA_PATTERN_EN
         end else if (s2_pat_q) begin
            reg_r <= {8{~s2_bar_q[1]}};
            reg_g <= {8{~s2_bar_q[2]}};
            reg_b <= {8{~s2_bar_q[0]}};
`endif
         end else begin
            reg_r <= pix_r;
            reg_g <= pix_g;
            reg_b <= pix_b;
         end
         hsync       <= SYNC_POL ? s2_hs_q : ~s2_hs_q;
         vsync       <= SYNC_POL ? s2_vs_q : ~s2_vs_q;
         blank_n     <= s2_act_q;
         frame_start <= s2_fs_q;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three rasters (default, medium, tiny active-high sync)
// run in lockstep against an arithmetic model indexed by the enabled-cycle count.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;
   logic pattern_sel = 1'b0;
   int   n;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   typedef struct packed {
      logic [9:0] px_x;
      logic [9:0] px_y;
      logic       px_valid;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      logic       hs;
      logic       vs;
      logic       blank_n;
      logic       fs;
   } obs_t;

   logic [9:0] d_px_x, d_px_y, m_px_x, m_px_y, t_px_x, t_px_y;
   logic       d_px_valid, m_px_valid, t_px_valid;
   logic [7:0] d_pix_r, d_pix_g, d_pix_b, m_pix_r, m_pix_g, m_pix_b, t_pix_r, t_pix_g, t_pix_b;
   logic [7:0] d_reg_r, d_reg_g, d_reg_b, m_reg_r, m_reg_g, m_reg_b, t_reg_r, t_reg_g, t_reg_b;
   logic       d_hsync, d_vsync, d_blank_n, d_fs;
   logic       m_hsync, m_vsync, m_blank_n, m_fs;
   logic       t_hsync, t_vsync, t_blank_n, t_fs;

   vga_timing_gen u_dflt (
      .clk(clk), .rst_n(rst_n), .en(en), .pattern_sel(pattern_sel),
      .px_x(d_px_x), .px_y(d_px_y), .px_valid(d_px_valid),
      .pix_r(d_pix_r), .pix_g(d_pix_g), .pix_b(d_pix_b),
      .reg_r(d_reg_r), .reg_g(d_reg_g), .reg_b(d_reg_b),
      .hsync(d_hsync), .vsync(d_vsync), .blank_n(d_blank_n), .frame_start(d_fs)
   );

   vga_timing_gen #(
      .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
      .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
   ) u_med (
      .clk(clk), .rst_n(rst_n), .en(en), .pattern_sel(pattern_sel),
      .px_x(m_px_x), .px_y(m_px_y), .px_valid(m_px_valid),
      .pix_r(m_pix_r), .pix_g(m_pix_g), .pix_b(m_pix_b),
      .reg_r(m_reg_r), .reg_g(m_reg_g), .reg_b(m_reg_b),
      .hsync(m_hsync), .vsync(m_vsync), .blank_n(m_blank_n), .frame_start(m_fs)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
   ) u_tiny (
      .clk(clk), .rst_n(rst_n), .en(en), .pattern_sel(pattern_sel),
      .px_x(t_px_x), .px_y(t_px_y), .px_valid(t_px_valid),
      .pix_r(t_pix_r), .pix_g(t_pix_g), .pix_b(t_pix_b),
      .reg_r(t_reg_r), .reg_g(t_reg_g), .reg_b(t_reg_b),
      .hsync(t_hsync), .vsync(t_vsync), .blank_n(t_blank_n), .frame_start(t_fs)
   );

   // Pixel sources: one-enabled-cycle read latency, data derived from the request
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_pix_r <= 8'h00; d_pix_g <= 8'h00; d_pix_b <= 8'h00;
         m_pix_r <= 8'h00; m_pix_g <= 8'h00; m_pix_b <= 8'h00;
         t_pix_r <= 8'h00; t_pix_g <= 8'h00; t_pix_b <= 8'h00;
      end else if (en) begin
         d_pix_r <= d_px_x[7:0]; d_pix_g <= d_px_y[7:0]; d_pix_b <= d_px_x[7:0] + d_px_y[7:0];
         m_pix_r <= m_px_x[7:0]; m_pix_g <= m_px_y[7:0]; m_pix_b <= m_px_x[7:0] + m_px_y[7:0];
         t_pix_r <= t_px_x[7:0]; t_pix_g <= t_px_y[7:0]; t_pix_b <= t_px_x[7:0] + t_px_y[7:0];
      end
   end

   // Enabled edges since reset release
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) n <= 0;
      else if (en) n <= n + 1;
   end

   // Expected outputs after cnt enabled edges: px_* shows raster position cnt-1,
   // the colour/sync outputs show position cnt-3.
   function automatic obs_t model(int cnt, int ha, int hfp, int hsw, int hbp,
                                  int va, int vfp, int vsw, int vbp, bit pol, bit pat);
      obs_t e;
      int   ht, vt, p, x, y, i;
      bit   act, hr, vr;
      ht = ha + hfp + hsw + hbp;
      vt = va + vfp + vsw + vbp;
      e = '0;
      e.hs = ~pol;
      e.vs = ~pol;
      if (cnt >= 1) begin
         p = cnt - 1;
         x = p % ht;
         y = (p / ht) % vt;
         e.px_x = 10'(x);
         e.px_y = 10'(y);
         e.px_valid = (x < ha) && (y < va);
      end
      if (cnt >= 3) begin
         p = cnt - 3;
         x = p % ht;
         y = (p / ht) % vt;
         act = (x < ha) && (y < va);
         hr = (x >= ha + hfp) && (x < ha + hfp + hsw);
         vr = (y >= va + vfp) && (y < va + vfp + vsw);
         e.hs = pol ? hr : !hr;
         e.vs = pol ? vr : !vr;
         e.blank_n = act;
         e.fs = act && (x == 0) && (y == 0);
         if (act) begin
            if (pat) begin
               i = x / (ha / 8);
               e.r = i[1] ? 8'h00 : 8'hff;
               e.g = i[2] ? 8'h00 : 8'hff;
               e.b = i[0] ? 8'h00 : 8'hff;
            end else begin
               e.r = 8'(x);
               e.g = 8'(y);
               e.b = 8'(x + y);
            end
         end
      end
      return e;
   endfunction

   task automatic cmp(input string nm, input obs_t got, input obs_t want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s n=%0d got=%h want=%h", nm, n, got, want);
      end
   endtask

   task automatic lit(input string nm, input int got, input int want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s n=%0d got=%0d want=%0d", nm, n, got, want);
      end
   endtask

   task automatic compare_all();
      bit pat;
`ifdef VGA_PATTERN_EN
      pat = pattern_sel;
`else
      pat = 1'b0;
`endif
      cmp("dflt", {d_px_x, d_px_y, d_px_valid, d_reg_r, d_reg_g, d_reg_b,
                   d_hsync, d_vsync, d_blank_n, d_fs},
          model(n, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, pat));
      cmp("med", {m_px_x, m_px_y, m_px_valid, m_reg_r, m_reg_g, m_reg_b,
                  m_hsync, m_vsync, m_blank_n, m_fs},
          model(n, 64, 4, 8, 4, 48, 2, 2, 3, 1'b0, pat));
      cmp("tiny", {t_px_x, t_px_y, t_px_valid, t_reg_r, t_reg_g, t_reg_b,
                   t_hsync, t_vsync, t_blank_n, t_fs},
          model(n, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, pat));
   endtask

   // One cycle: check on the falling edge, leave room to drive inputs before the rise
   task automatic step();
      @(negedge clk);
      compare_all();
      #2;
   endtask

   task automatic wait_n(input int target);
      int k;
      k = 0;
      while (n != target && k < 20000) begin
         step();
         k++;
      end
      if (n != target) begin
         total++;
         bad++;
         $display("FAIL wait_n got=%0d want=%0d", n, target);
      end
   endtask

   initial begin
      int tgt;
      step();
      step();
      lit("rst_hsync", int'(d_hsync), 1);
      lit("rst_blank", int'(d_blank_n), 0);
      lit("rst_valid", int'(d_px_valid), 0);
      lit("rst_tiny_hsync", int'(t_hsync), 0);
      rst_n = 1'b1;
      en = 1'b1;
      wait_n(1);
      lit("first_valid", int'(d_px_valid), 1);
      lit("first_x", int'(d_px_x), 0);
      lit("first_blank", int'(d_blank_n), 0);
      wait_n(3);
      lit("third_blank", int'(d_blank_n), 1);
      lit("third_fs", int'(d_fs), 1);
      wait_n(13);  lit("tiny_hs_on", int'(t_hsync), 1);
      wait_n(15);  lit("tiny_hs_off", int'(t_hsync), 0);
      wait_n(73);  lit("tiny_vs_on", int'(t_vsync), 1);
      wait_n(100); lit("tiny_fs_97", int'(t_fs), 0);
      wait_n(101); lit("tiny_fs_98", int'(t_fs), 1);
      wait_n(658); lit("hs_655", int'(d_hsync), 1);
      wait_n(659); lit("hs_656", int'(d_hsync), 0);
      wait_n(754); lit("hs_751", int'(d_hsync), 0);
      wait_n(755); lit("hs_752", int'(d_hsync), 1);
      wait_n(803);
      lit("line1_r", int'(d_reg_r), 0);
      lit("line1_g", int'(d_reg_g), 1);
      wait_n(4002); lit("med_vs_49", int'(m_vsync), 1);
      wait_n(4003); lit("med_vs_50", int'(m_vsync), 0);
      wait_n(4403); lit("med_frame", int'(m_fs), 1);

      // Random enable gaps
      for (int c = 0; c < 9000; c++) begin
         step();
         en = 1'($urandom_range(0, 1));
`ifndef VGA_PATTERN_EN
         pattern_sel = 1'($urandom_range(0, 1));
`endif
      end

      // Reset in the middle of a medium frame at (30, 20)
      en = 1'b1;
      pattern_sel = 1'b0;
      step();
      tgt = n + (((1630 - (n - 3)) % 4400) + 4400) % 4400;
      wait_n(tgt);
      lit("mid_pre_r", int'(m_reg_r), 30);
      rst_n = 1'b0;
      #1;
      lit("mid_rst_blank", int'(m_blank_n), 0);
      lit("mid_rst_r", int'(m_reg_r), 0);
      lit("mid_rst_x", int'(m_px_x), 0);
      lit("mid_rst_hsync", int'(m_hsync), 1);
      step();
      step();
      rst_n = 1'b1;
      wait_n(3);
      lit("mid_fs", int'(m_fs), 1);
      lit("mid_fs_r", int'(m_reg_r), 0);

`ifdef VGA_PATTERN_EN
      rst_n = 1'b0;
      pattern_sel = 1'b1;
      step();
      rst_n = 1'b1;
      wait_n(3);   lit("bar0", int'({d_reg_r, d_reg_g, d_reg_b}), 32'hffffff);
      wait_n(82);  lit("bar0_end", int'({d_reg_r, d_reg_g, d_reg_b}), 32'hffffff);
      wait_n(83);  lit("bar1", int'({d_reg_r, d_reg_g, d_reg_b}), 32'hffff00);
      wait_n(163); lit("bar2", int'({d_reg_r, d_reg_g, d_reg_b}), 32'h00ffff);
      wait_n(603); lit("bar7", int'({d_reg_r, d_reg_g, d_reg_b}), 32'h000000);
      wait_n(700);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Generates VGA raster timing (hsync, vsync, blank) and the pixel coordinate stream.
- Fetches colour from an upstream pixel source with fixed one-cycle read latency.
- Drives the registered 8-bit reg_r/reg_g/reg_b buses that the pin-assignment stage fans out to the DAC pins.
- Sits directly upstream of the RGB pin stage; sync, blank and colour leave this block mutually cycle-aligned.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line (multiple of 8)
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync asserted level (0 = active-low, 1 = active-high)

Ports. One clock; reset is asynchronous and active-low.
- clk  in  1  pixel-domain clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  pixel clock enable; all state advances only when en=1
- pattern_sel  in  1  selects internal colour bars (effective only with VGA_PATTERN_EN)
- px_x  out  10  requested pixel column
- px_y  out  10  requested pixel row
- px_valid  out  1  px_x/px_y lie in the active area
- pix_r / pix_g / pix_b  in  8 each  source colour for the previous enabled cycle's request
- reg_r / reg_g / reg_b  out  8 each  registered colour to the pin stage
- hsync, vsync  out  1 each  registered sync
- blank_n  out  1  1 = colour outputs are in the active area
- frame_start  out  1  one-enabled-cycle pulse on the output of pixel (0,0)

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Counter h_cnt: 0..H_TOTAL-1, increments on every enabled cycle and wraps to 0.
- Counter v_cnt: increments when h_cnt wraps; wraps from V_TOTAL-1 to 0 on the same edge.
- Active area: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- Hsync asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
- Vsync asserted for the analogous v_cnt range.
- Stage 1 (registered from counters):
  - px_x = h_cnt, px_y = v_cnt, px_valid = active.
  - Delayed hsync, vsync and active level travel alongside.
  - px_x/px_y are driven even in blanking; the source ignores them when px_valid=0.
- Stage 2 (registered):
  - reg_* = pix_* if stage-1 active, else 8'h00.
  - hsync/vsync = SYNC_POL ? raw : ~raw.
  - blank_n = stage-1 active.
  - frame_start = stage-1 active && x==0 && y==0.
- Source contract: pix_* must be valid on the enabled cycle after the corresponding px_* request.
- Colour outputs are always 0 whenever blank_n=0; upstream data is never passed during blanking.

## Timing
- Reset values:
  - h_cnt, v_cnt, px_x, px_y = 0; px_valid = 0.
  - reg_r/g/b = 0; blank_n = 0; frame_start = 0.
  - hsync/vsync = deasserted level (1 when SYNC_POL=0).
- Latency: counters -> px_* is 1 enabled cycle; px_* -> reg_*/sync/blank_n is 2 enabled cycles.
- After rst_n rises with en=1:
  - First edge: px_valid=1, px_x=0.
  - Third edge: blank_n=1, frame_start=1.
- en=0: every register holds; outputs remain stable; alignment is preserved across any en gap.
- Reset mid-frame: all state returns to the reset values asynchronously; raster restarts at (0,0).
- Line wrap: h_cnt H_TOTAL-1 -> 0 and v_cnt increment happen on the same edge.
- Frame wrap: (H_TOTAL-1, V_TOTAL-1) -> (0,0) on a single edge.

## Configuration
- VGA_PATTERN_EN defined:
  - With pattern_sel=1, stage 2 ignores pix_* and outputs 8 equal-width colour bars in the active area.
  - Bar width is H_ACTIVE/8; bar index i = x/(H_ACTIVE/8).
  - R = ~i[1], G = ~i[2], B = ~i[0], each expanded to 8'hFF / 8'h00 (white, yellow, cyan, green, magenta, red, blue, black).
  - Pattern colour is aligned identically to source colour; pattern_sel is sampled at stage 1.
- VGA_PATTERN_EN undefined: pattern logic is absent, pattern_sel is unused, and pix_* is always used.

## Test plan
- Reset release, en=1 at default parameters, stimulus held for 1 frame:
  - Measure 800 cycles per line and 525 lines per frame.
  - hsync low for exactly 96 cycles starting at output column 656.
  - vsync low for 2 lines starting at line 490.
- Source model returns pix_r = px_x[7:0], pix_g = px_y[7:0] one cycle later:
  - reg_r equals column index on every blank_n=1 cycle.
  - reg_* = 0 on all blank_n=0 cycles.
- en toggled 1-0-1 pseudo-randomly (about 50%):
  - Frame length is 420000 enabled cycles.
  - No output changes on en=0 cycles.
  - Colour/sync alignment identical to the en=1 run.
- rst_n asserted at h=300, v=200:
  - Outputs immediately take the reset values.
  - After release, frame_start fires 3 enabled cycles later with reg_r = 0 (column 0).
- VGA_PATTERN_EN defined, pattern_sel=1:
  - Columns 0..79 output FF/FF/FF.
  - Columns 80..159 output FF/FF/00.
  - Columns 560..639 output 00/00/00.
  - Pixel source data ignored.
- SYNC_POL=1 with a small raster (H 8/2/2/2, V 4/1/1/1):
  - hsync high 2 cycles per 14-cycle line.
  - vsync high 1 line per 7-line frame.
  - frame_start once per 98 cycles.
